// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand/result handshake bundle for nibble_serial_add_ctrl.
//   master : operand producer / result consumer (drives operands, res_ready)
//   slave  : the nibble-serial controller (drives start_ready, results, busy)
// Signals:
//   start_valid/start_ready : operand handshake
//   a, b, cin, sub          : operands, carry-in (add only), subtract select
//   res_valid/res_ready     : result handshake
//   sum, cout, ovf          : result, MSB carry (sub: 1 = no borrow), signed overflow
//   busy                    : operation in flight or result pending
interface nibble_serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output start_valid, a, b, cin, sub, res_ready,
    input  start_ready, res_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  start_valid, a, b, cin, sub, res_ready,
    output start_ready, res_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add/subtract controller. One shared 4-bit adder slice is
// stepped across WIDTH-bit operands, LSB nibble first, one nibble per clock,
// with the inter-nibble carry held in a register.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of nibble_serial_add_ctrl_if (operand and result
//         valid/ready handshakes, result flags, busy)
// Accept at edge k -> res_valid high after edge k+NIB. Results hold until the
// next operation completes.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  nibble_serial_add_ctrl_if.slave bus
);
  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [4:0]       nib_res;
  logic             last_nib;

  logic             start_ready_r;
  logic             res_valid_r;
  logic             busy_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  // The shared 4-bit ripple slice: {carry_out, sum_nibble}.
  function automatic logic [4:0] bit4_full_add(input logic [3:0] x,
                                               input logic [3:0] y,
                                               input logic       c);
    return {1'b0, x} + {1'b0, y} + {4'b0000, c};
  endfunction

  always_comb begin
    a_nib    = a_reg[{idx, 2'b00} +: 4];
    b_nib    = b_reg[{idx, 2'b00} +: 4];
    nib_res  = bit4_full_add(a_nib, b_nib, carry);
    // Working copy of the result with the current nibble merged in; on the
    // last nibble this is the complete sum published to the outputs.
    acc_next = acc;
    acc_next[{idx, 2'b00} +: 4] = nib_res[3:0];
    last_nib = (idx == IDX_W'(NIB - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      carry         <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      acc           <= '0;
      start_ready_r <= 1'b1;
      res_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
      sum_r         <= '0;
      cout_r        <= 1'b0;
      ovf_r         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start_valid) begin
            // Subtract is A + ~B + 1: invert B once here and seed the carry.
            a_reg         <= bus.a;
            b_reg         <= bus.sub ? ~bus.b : bus.b;
            carry         <= bus.sub ? 1'b1 : bus.cin;
            idx           <= '0;
            start_ready_r <= 1'b0;
            busy_r        <= 1'b1;
            state         <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          carry <= nib_res[4];
          idx   <= idx + 1'b1;
          if (last_nib) begin
            sum_r       <= acc_next;
            cout_r      <= nib_res[4];
            ovf_r       <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                           (acc_next[WIDTH-1] != a_reg[WIDTH-1]);
            res_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          // No same-cycle handoff: start_ready rises only once back in IDLE.
          if (bus.res_ready) begin
            res_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
            start_ready_r <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          start_ready_r <= 1'b1;
          res_valid_r   <= 1'b0;
          busy_r        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.start_ready = start_ready_r;
  assign bus.res_valid   = res_valid_r;
  assign bus.busy        = busy_r;
  assign bus.sum         = sum_r;
  assign bus.cout        = cout_r;
  assign bus.ovf         = ovf_r;
endmodule
